memref_port_arb: RTL and testbench

// - Shares one physical memref port (memref_rd/memref_wr pair on a common address) between two kernel-side requesters.
// - Lets a kernel with separate p0 (read) and p1 (write) ports run against a single-ported 1024x32 bank.
// - Sits between the kernel instance (HIR or HLS) and the memref models in the jacobi_2d bench and in synthesis wrappers.

---
 rtl/memref_port_arb.sv | 105 ++++++++++
 tb/tb_memref_port_arb.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memref_port_arb.sv
// Two-requester arbiter sharing one single-ported memref (read/write on a common address).
// Requests are granted combinationally, and read data returns through a tag pipe matched to the memory read latency.
module memref_port_arb #(
   parameter int WIDTH     = 32,
   parameter int ADDR_W    = 10,
   parameter int RD_LAT    = 1,
   parameter int PRIO_MODE = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              r0_req,
   input  logic              r0_we,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [WIDTH-1:0]  r0_wdata,
   output logic              r0_gnt,
   output logic              r0_rvalid,
   output logic [WIDTH-1:0]  r0_rdata,
   input  logic              r1_req,
   input  logic              r1_we,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [WIDTH-1:0]  r1_wdata,
   output logic              r1_gnt,
   output logic              r1_rvalid,
   output logic [WIDTH-1:0]  r1_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WIDTH-1:0]  mem_wdata,
   input  logic [WIDTH-1:0]  mem_rdata,
   output logic [15:0]       conflict_cnt
);

   typedef struct packed {
      logic valid;
      logic id;
   } tag_t;

   logic rr_ptr;  // requester that wins the next conflict in round-robin mode
   tag_t tag_pipe [RD_LAT];
   tag_t tag_push;
   tag_t tag_out;

   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      r0_gnt = 1'b0;
      r1_gnt = 1'b0;
      if (!rst) begin
         if (r0_req && r1_req) begin
            if (PRIO_MODE != 0 || !rr_ptr) r0_gnt = 1'b1;
            else                           r1_gnt = 1'b1;
         end else begin
            r0_gnt = r0_req;
            r1_gnt = r1_req;
         end
      end
   end

   always_comb begin
      mem_en    = r0_gnt | r1_gnt;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (r0_gnt) begin
         mem_we    = r0_we;
         mem_addr  = r0_addr;
         mem_wdata = r0_wdata;
      end else if (r1_gnt) begin
         mem_we    = r1_we;
         mem_addr  = r1_addr;
         mem_wdata = r1_wdata;
      end
   end

   assign tag_push = '{valid: mem_en & ~mem_we, id: r1_gnt};
   assign tag_out  = tag_pipe[RD_LAT-1];

   // NOTE: all state below updates with non-blocking assignments, so every stage sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr       <= 1'b0;
         r0_rvalid    <= 1'b0;
         r1_rvalid    <= 1'b0;
         r0_rdata     <= '0;
         r1_rdata     <= '0;
         conflict_cnt <= '0;
         for (int i = 0; i < RD_LAT; i++) tag_pipe[i] <= '0;
      end else begin
         if (r0_gnt)      rr_ptr <= 1'b1;
         else if (r1_gnt) rr_ptr <= 1'b0;

         tag_pipe[0] <= tag_push;
         for (int i = 1; i < RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];

         // mem_rdata is valid exactly when the tag reaches the last stage
         r0_rvalid <= tag_out.valid & ~tag_out.id;
         r1_rvalid <= tag_out.valid &  tag_out.id;
         if (tag_out.valid && !tag_out.id) r0_rdata <= mem_rdata;
         if (tag_out.valid &&  tag_out.id) r1_rdata <= mem_rdata;

         if (r0_req && r1_req && conflict_cnt != 16'hFFFF)
            conflict_cnt <= conflict_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_memref_port_arb.sv
// Bench for memref_port_arb: a round-robin and a fixed-priority instance driven by shared stimulus.
// A transaction-level model predicts every output each cycle; directed checks pin the model.
module tb_memref_port_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        r0_req, r0_we, r1_req, r1_we;
   logic [9:0]  r0_addr, r1_addr;
   logic [31:0] r0_wdata, r1_wdata;

   logic        r0_gnt_v [2];
   logic        r1_gnt_v [2];
   logic        r0_rvalid_v [2];
   logic        r1_rvalid_v [2];
   logic [31:0] r0_rdata_v [2];
   logic [31:0] r1_rdata_v [2];
   logic        mem_en_v [2];
   logic        mem_we_v [2];
   logic [9:0]  mem_addr_v [2];
   logic [31:0] mem_wdata_v [2];
   logic [31:0] mem_rdata_v [2];
   logic [15:0] cnt_v [2];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      memref_port_arb #(.WIDTH(32), .ADDR_W(10), .RD_LAT(1), .PRIO_MODE(g)) dut (
         .clk(clk), .rst(rst),
         .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
         .r0_gnt(r0_gnt_v[g]), .r0_rvalid(r0_rvalid_v[g]), .r0_rdata(r0_rdata_v[g]),
         .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
         .r1_gnt(r1_gnt_v[g]), .r1_rvalid(r1_rvalid_v[g]), .r1_rdata(r1_rdata_v[g]),
         .mem_en(mem_en_v[g]), .mem_we(mem_we_v[g]), .mem_addr(mem_addr_v[g]),
         .mem_wdata(mem_wdata_v[g]), .mem_rdata(mem_rdata_v[g]), .conflict_cnt(cnt_v[g])
      );
   end

   // Single-ported 1024x32 banks behind each instance, one cycle read latency
   logic [31:0] bmem [2][1024];
   always @(posedge clk) begin
      for (int m = 0; m < 2; m++) begin
         if (mem_en_v[m]) begin
            if (mem_we_v[m]) bmem[m][mem_addr_v[m]] <= mem_wdata_v[m];
            else             mem_rdata_v[m] <= bmem[m][mem_addr_v[m]];
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pending reads are returned two cycles after their grant
   typedef struct {
      int          due;
      int          m;
      bit          id;
      logic [31:0] data;
   } pend_t;

   logic [31:0] mmem [2][1024];
   bit          mptr [2];
   int          mcnt [2];
   bit          mrv  [2][2];
   logic [31:0] mrd  [2][2];
   pend_t       pend [$];
   int          cyc = 0;
   bit          started = 1'b0;

   always @(negedge clk) begin
      pend_t keep [$];
      for (int m = 0; m < 2; m++) begin
         bit          e0, e1;
         logic        we;
         logic [9:0]  a;
         logic [31:0] wd;
         e0 = 1'b0;
         e1 = 1'b0;
         if (!rst) begin
            if (r0_req && r1_req) begin
               if (m == 1 || !mptr[m]) e0 = 1'b1;
               else                    e1 = 1'b1;
            end else begin
               e0 = r0_req;
               e1 = r1_req;
            end
         end
         we = e0 ? r0_we    : (e1 ? r1_we    : 1'b0);
         a  = e0 ? r0_addr  : (e1 ? r1_addr  : 10'd0);
         wd = e0 ? r0_wdata : (e1 ? r1_wdata : 32'd0);

         if (started) begin
            check($sformatf("m%0d r0_gnt", m), {31'd0, r0_gnt_v[m]}, {31'd0, e0});
            check($sformatf("m%0d r1_gnt", m), {31'd0, r1_gnt_v[m]}, {31'd0, e1});
            check($sformatf("m%0d mem_en", m), {31'd0, mem_en_v[m]}, {31'd0, e0 | e1});
            check($sformatf("m%0d mem_we", m), {31'd0, mem_we_v[m]}, {31'd0, we});
            check($sformatf("m%0d mem_addr", m), {22'd0, mem_addr_v[m]}, {22'd0, a});
            check($sformatf("m%0d mem_wdata", m), mem_wdata_v[m], wd);
            check($sformatf("m%0d r0_rvalid", m), {31'd0, r0_rvalid_v[m]}, {31'd0, mrv[m][0]});
            check($sformatf("m%0d r1_rvalid", m), {31'd0, r1_rvalid_v[m]}, {31'd0, mrv[m][1]});
            check($sformatf("m%0d r0_rdata", m), r0_rdata_v[m], mrd[m][0]);
            check($sformatf("m%0d r1_rdata", m), r1_rdata_v[m], mrd[m][1]);
            check($sformatf("m%0d conflict_cnt", m), {16'd0, cnt_v[m]}, mcnt[m]);
         end

         if (rst) begin
            mptr[m]   = 1'b0;
            mcnt[m]   = 0;
            mrv[m][0] = 1'b0;
            mrv[m][1] = 1'b0;
            mrd[m][0] = '0;
            mrd[m][1] = '0;
         end else begin
            mrv[m][0] = 1'b0;
            mrv[m][1] = 1'b0;
            foreach (pend[i]) begin
               if (pend[i].m == m && pend[i].due == cyc + 1) begin
                  mrv[m][pend[i].id] = 1'b1;
                  mrd[m][pend[i].id] = pend[i].data;
               end
            end
            if (e0 || e1) begin
               if (we) mmem[m][a] = wd;
               else    pend.push_back('{cyc + 2, m, e1, mmem[m][a]});
               mptr[m] = e0;
            end
            if (r0_req && r1_req && mcnt[m] < 65535) mcnt[m]++;
         end
      end
      keep = {};
      foreach (pend[i]) if (!rst && pend[i].due > cyc + 1) keep.push_back(pend[i]);
      pend = keep;
      cyc++;
      started = 1'b1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      r0_req = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
      r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;
   endtask

   task automatic preload(input int addr, input logic [31:0] data);
      for (int m = 0; m < 2; m++) begin
         bmem[m][addr] = data;
         mmem[m][addr] = data;
      end
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      for (int i = 0; i < 1024; i++) preload(i, 32'd0);
      for (int m = 0; m < 2; m++) mem_rdata_v[m] = '0;
      preload(5, 32'hA5);
      preload(1, 32'h11);
      preload(2, 32'h22);
      repeat (3) step();
      rst = 1'b0;

      // Idle after reset
      repeat (10) step();
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
         check("idle mem_en", {31'd0, mem_en_v[m]}, 32'd0);
         check("idle gnt", {30'd0, r0_gnt_v[m], r1_gnt_v[m]}, 32'd0);
         check("idle rvalid", {30'd0, r0_rvalid_v[m], r1_rvalid_v[m]}, 32'd0);
         check("idle cnt", {16'd0, cnt_v[m]}, 32'd0);
      end

      // Single read of addr 5
      step();
      r0_req = 1'b1; r0_addr = 10'd5;
      @(negedge clk);
      for (int m = 0; m < 2; m++) check("rd5 r0_gnt", {31'd0, r0_gnt_v[m]}, 32'd1);
      step();
      idle();
      step();
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
         check("rd5 r0_rvalid", {31'd0, r0_rvalid_v[m]}, 32'd1);
         check("rd5 r0_rdata", r0_rdata_v[m], 32'hA5);
         check("rd5 r1_rvalid", {31'd0, r1_rvalid_v[m]}, 32'd0);
      end

      // Both read for 4 cycles from a fresh pointer
      step();
      reset_pulse();
      r0_req = 1'b1; r0_addr = 10'd1;
      r1_req = 1'b1; r1_addr = 10'd2;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("rr r0_gnt", {31'd0, r0_gnt_v[0]}, (k % 2 == 0) ? 32'd1 : 32'd0);
         check("rr r1_gnt", {31'd0, r1_gnt_v[0]}, (k % 2 == 1) ? 32'd1 : 32'd0);
         check("pri r0_gnt", {31'd0, r0_gnt_v[1]}, 32'd1);
         step();
      end
      idle();
      @(negedge clk);
      check("rr cnt", {16'd0, cnt_v[0]}, 32'd4);
      check("pri cnt", {16'd0, cnt_v[1]}, 32'd4);
      check("rr r0_rvalid", {31'd0, r0_rvalid_v[0]}, 32'd1);
      check("rr r0_rdata", r0_rdata_v[0], 32'h11);
      step();
      @(negedge clk);
      check("rr r1_rvalid", {31'd0, r1_rvalid_v[0]}, 32'd1);
      check("rr r1_rdata", r1_rdata_v[0], 32'h22);

      // Fixed priority: both request for 8 cycles
      step();
      reset_pulse();
      r0_req = 1'b1; r0_addr = 10'd3;
      r1_req = 1'b1; r1_addr = 10'd4;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check("pri8 r0_gnt", {31'd0, r0_gnt_v[1]}, 32'd1);
         check("pri8 r1_gnt", {31'd0, r1_gnt_v[1]}, 32'd0);
         step();
      end
      idle();
      @(negedge clk);
      check("pri8 cnt", {16'd0, cnt_v[1]}, 32'd8);
      repeat (3) step();

      // r1 writes 7, then r0 reads it back
      r1_req = 1'b1; r1_we = 1'b1; r1_addr = 10'd7; r1_wdata = 32'hDEAD;
      @(negedge clk);
      for (int m = 0; m < 2; m++) check("wr7 r1_gnt", {31'd0, r1_gnt_v[m]}, 32'd1);
      step();
      idle();
      r0_req = 1'b1; r0_addr = 10'd7;
      step();
      idle();
      step();
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
         check("rd7 r0_rvalid", {31'd0, r0_rvalid_v[m]}, 32'd1);
         check("rd7 r0_rdata", r0_rdata_v[m], 32'hDEAD);
      end

      // Same-address write and read in the same cycle; order follows arbitration
      step();
      r0_req = 1'b1; r0_we = 1'b1; r0_addr = 10'd9; r0_wdata = 32'h1234;
      r1_req = 1'b1; r1_addr = 10'd9;
      repeat (2) step();
      idle();
      repeat (3) step();

      // Reset while a read is in flight
      r0_req = 1'b1; r0_addr = 10'd5;
      @(negedge clk);
      for (int m = 0; m < 2; m++) check("rst r0_gnt", {31'd0, r0_gnt_v[m]}, 32'd1);
      step();
      idle();
      reset_pulse();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         for (int m = 0; m < 2; m++) begin
            check("rst r0_rvalid", {31'd0, r0_rvalid_v[m]}, 32'd0);
            check("rst r0_rdata", r0_rdata_v[m], 32'd0);
            check("rst r1_rdata", r1_rdata_v[m], 32'd0);
            check("rst mem_en", {31'd0, mem_en_v[m]}, 32'd0);
            check("rst cnt", {16'd0, cnt_v[m]}, 32'd0);
         end
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
